// File: rtl/cla_pipe_adder_pkg.sv
// rtl/cla_pipe_adder_pkg.sv - shared constants for the pipelined carry-lookahead adder
package cla_pipe_adder_pkg;
  localparam int NIB_W      = 4;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_GROUPS = DEF_WIDTH / NIB_W;

  function automatic int num_groups(input int width);
    return width / NIB_W;
  endfunction
endpackage

// File: rtl/cla_lookahead_4.sv
// rtl/cla_lookahead_4.sv - 4-bit lookahead cell: group G/P and flattened carries c1..c4
module cla_lookahead_4
  import cla_pipe_adder_pkg::*;
(
  input  logic [NIB_W-1:0] g,
  input  logic [NIB_W-1:0] p,
  input  logic             c0,
  output logic [NIB_W-1:0] c,
  output logic             grp_g,
  output logic             grp_p
);
  // c[i] is the carry into position i+1; every term is a flat sum of products.
  assign c[0] = g[0] | (p[0] & c0);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c[3] = grp_g | (grp_p & c0);

  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;
endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage valid/ready carry-lookahead adder
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_g,
  output logic             grp_p,
  output logic             ovf
);
  localparam int NG = num_groups(WIDTH);
  localparam int NB = (NG + NIB_W - 1) / NIB_W;

  logic             s1_valid, s1_cin, s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_g, s1_p, g_in, p_in, unused_cz;
  logic [NG-1:0]    s1_gg, s1_gp, gg_in, gp_in, unused_g2, unused_p2;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign g_in = a & b;
  assign p_in = a ^ b;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    cla_lookahead_4 u_grp (
      .g(g_in[NIB_W*j +: NIB_W]), .p(p_in[NIB_W*j +: NIB_W]), .c0(1'b0),
      .c(unused_cz[NIB_W*j +: NIB_W]), .grp_g(gg_in[j]), .grp_p(gp_in[j])
    );
  end

  // Unused top slots of the second level are padded as pure propagate so carries pass through.
  logic [NIB_W*NB-1:0] pad_g, pad_p;
  logic [NIB_W*NB:0]   nib_c;
  logic [NB-1:0]       blk_g, blk_p;

  always_comb begin
    pad_g = '0;
    pad_p = '1;
    pad_g[NG-1:0] = s1_gg;
    pad_p[NG-1:0] = s1_gp;
  end

  assign nib_c[0] = s1_cin;
  for (genvar k = 0; k < NB; k++) begin : g_lvl2
    cla_lookahead_4 u_lvl2 (
      .g(pad_g[NIB_W*k +: NIB_W]), .p(pad_p[NIB_W*k +: NIB_W]), .c0(nib_c[NIB_W*k]),
      .c(nib_c[NIB_W*k+1 +: NIB_W]), .grp_g(blk_g[k]), .grp_p(blk_p[k])
    );
  end

  logic [WIDTH:0] carry;
  assign carry[0] = s1_cin;
  for (genvar j = 0; j < NG; j++) begin : g_bit
    cla_lookahead_4 u_bit (
      .g(s1_g[NIB_W*j +: NIB_W]), .p(s1_p[NIB_W*j +: NIB_W]), .c0(nib_c[j]),
      .c(carry[NIB_W*j+1 +: NIB_W]), .grp_g(unused_g2[j]), .grp_p(unused_p2[j])
    );
  end

  logic word_g, unused_tail;
  always_comb begin
    word_g = 1'b0;
    for (int k = 0; k < NB; k++) word_g = blk_g[k] | (blk_p[k] & word_g);
  end
  assign unused_tail = ^{nib_c, carry[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_g      <= '0;
      s1_p      <= '0;
      s1_gg     <= '0;
      s1_gp     <= '0;
      s1_cin    <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      grp_g     <= 1'b0;
      grp_p     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_g   <= g_in;
          s1_p   <= p_in;
          s1_gg  <= gg_in;
          s1_gp  <= gp_in;
          s1_cin <= cin;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sum   <= s1_p ^ carry[WIDTH-1:0];
          cout  <= nib_c[NG];
          grp_g <= word_g;
          grp_p <= &blk_p;
          ovf   <= carry[WIDTH-1] ^ nib_c[NG];
        end
      end
    end
  end
endmodule
